// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: ALUControl opcodes, FSM states and
// the shift-opcode classifier.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_NOT   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_SUMA  = 4'b0100;
   localparam logic [3:0] OP_RESTA = 4'b0101;
   localparam logic [3:0] OP_LOG_I = 4'b0110;
   localparam logic [3:0] OP_LOG_D = 4'b0111;
   localparam logic [3:0] OP_ARI_I = 4'b1000;
   localparam logic [3:0] OP_ARI_D = 4'b1001;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_EXEC = 2'd2,
      S_RESP = 2'd3
   } state_t;

   function automatic logic is_shift(input logic [3:0] op);
      return (op >= OP_LOG_I) && (op <= OP_ARI_D);
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Host-side bundle of the sequencer: register load port, command port and
// response port.
interface alu_sequencer_if #(
   parameter int N    = 4,
   parameter int NREG = 4,
   parameter int CW   = 3
);
   localparam int AW = $clog2(NREG);

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [N-1:0]  wr_data;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [3:0]    cmd_op;
   logic [AW-1:0] cmd_ra;
   logic [AW-1:0] cmd_rb;
   logic [AW-1:0] cmd_rd;
   logic [CW-1:0] cmd_count;

   logic          res_valid;
   logic          res_ready;
   logic [N-1:0]  res_data;
   logic [2:0]    res_flags;

   modport master (
      output wr_en, wr_addr, wr_data,
      output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_count,
      output res_ready,
      input  cmd_ready, res_valid, res_data, res_flags
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_count,
      input  res_ready,
      output cmd_ready, res_valid, res_data, res_flags
   );

endinterface

// File: rtl/alu_regfile.sv
// NREG x N register file: one synchronous write port, two combinational read
// ports, cleared by the asynchronous reset.
module alu_regfile #(
   parameter int N    = 4,
   parameter int NREG = 4,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [N-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   input  logic [AW-1:0] raddr_b_i,
   output logic [N-1:0]  rdata_a_o,
   output logic [N-1:0]  rdata_b_o
);

   logic [N-1:0] mem_q [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven controller for the shared combinational ALU: fetches operands
// from the local register file, iterates shifts, writes back and responds.
//
// state  | meaning
// S_IDLE | waiting for a command; host register loads accepted
// S_LOAD | registered read of RF[ra], RF[rb] into op_a/op_b
// S_EXEC | ALU driven; op_a <= Y each edge until the iteration count expires
// S_RESP | result and flags held until res_ready
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int N    = 4,
   parameter int NREG = 4,
   parameter int CW   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_sequencer_if.slave     bus,
   output logic               busy_o,
   output logic [N-1:0]       alu_a_o,
   output logic [N-1:0]       alu_b_o,
   output logic [3:0]         alu_ctrl_o,
   input  logic [N-1:0]       alu_y_i,
   input  logic [2:0]         alu_flags_i
);

   localparam int AW = $clog2(NREG);

   state_t        state_q, state_d;
   logic [3:0]    op_q;
   logic [AW-1:0] ra_q, rb_q, rd_q;
   logic [CW-1:0] iter_q, iter_init;
   logic [N-1:0]  op_a_q, op_b_q, res_data_q;
   logic [2:0]    res_flags_q;

   logic          last_iter;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [N-1:0]  rf_wdata, rf_rd_a, rf_rd_b;
   logic          cmd_ready, res_valid;

   assign last_iter = (iter_q == CW'(1));

   // Shift count 0 runs once; non-shift ops always take one EXEC cycle.
   assign iter_init = (is_shift(bus.cmd_op) && (bus.cmd_count != '0)) ? bus.cmd_count : CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.cmd_valid) state_d = S_LOAD;
         S_LOAD:  state_d = S_EXEC;
         S_EXEC:  if (last_iter) state_d = S_RESP;
         S_RESP:  if (bus.res_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready  = (state_q == S_IDLE);
      res_valid  = (state_q == S_RESP);
      busy_o     = (state_q != S_IDLE);
      alu_a_o    = '0;
      alu_b_o    = '0;
      alu_ctrl_o = '0;
      if (state_q == S_EXEC) begin
         alu_a_o    = op_a_q;
         alu_b_o    = op_b_q;
         alu_ctrl_o = op_q;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.res_valid = res_valid;
   assign bus.res_data  = res_data_q;
   assign bus.res_flags = res_flags_q;

   // Host loads only land in IDLE; write-back only on the final EXEC edge.
   assign rf_we    = ((state_q == S_IDLE) && bus.wr_en) || ((state_q == S_EXEC) && last_iter);
   assign rf_waddr = (state_q == S_EXEC) ? rd_q : bus.wr_addr;
   assign rf_wdata = (state_q == S_EXEC) ? alu_y_i : bus.wr_data;

   alu_regfile #(.N(N), .NREG(NREG), .AW(AW)) u_rf (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (rf_we),
      .waddr_i   (rf_waddr),
      .wdata_i   (rf_wdata),
      .raddr_a_i (ra_q),
      .raddr_b_i (rb_q),
      .rdata_a_o (rf_rd_a),
      .rdata_b_o (rf_rd_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= '0;
         ra_q        <= '0;
         rb_q        <= '0;
         rd_q        <= '0;
         iter_q      <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         res_data_q  <= '0;
         res_flags_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  op_q   <= bus.cmd_op;
                  ra_q   <= bus.cmd_ra;
                  rb_q   <= bus.cmd_rb;
                  rd_q   <= bus.cmd_rd;
                  iter_q <= iter_init;
               end
            end
            S_LOAD: begin
               op_a_q <= rf_rd_a;
               op_b_q <= rf_rd_b;
            end
            S_EXEC: begin
               op_a_q <= alu_y_i;
               iter_q <= iter_q - CW'(1);
               if (last_iter) begin
                  res_data_q  <= alu_y_i;
                  res_flags_q <= alu_flags_i;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 4-bit ALU closing the loop.
module tb_alu_sequencer;
   import alu_pkg::*;

   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic         busy;
   logic [N-1:0] alu_a, alu_b, alu_y;
   logic [3:0]   alu_ctrl;
   logic [2:0]   alu_flags;

   alu_sequencer_if #(.N(N), .NREG(4), .CW(3)) bus ();

   alu_sequencer #(.N(N), .NREG(4), .CW(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .busy_o      (busy),
      .alu_a_o     (alu_a),
      .alu_b_o     (alu_b),
      .alu_ctrl_o  (alu_ctrl),
      .alu_y_i     (alu_y),
      .alu_flags_i (alu_flags)
   );

   // Shared ALU: {negativo, cero, acarreo}; carry only from suma/resta.
   logic       alu_c;
   logic [N:0] wide;
   logic [N-1:0] nb;
   always_comb begin
      alu_y = '0;
      alu_c = 1'b0;
      nb    = ~alu_b;
      wide  = '0;
      case (alu_ctrl)
         OP_AND:   alu_y = alu_a & alu_b;
         OP_OR:    alu_y = alu_a | alu_b;
         OP_NOT:   alu_y = ~alu_a;
         OP_XOR:   alu_y = alu_a ^ alu_b;
         OP_SUMA:  begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_y = wide[N-1:0]; alu_c = wide[N]; end
         OP_RESTA: begin wide = {1'b0, alu_a} + {1'b0, nb} + 5'd1; alu_y = wide[N-1:0]; alu_c = wide[N]; end
         OP_LOG_I: alu_y = alu_a << 1;
         OP_LOG_D: alu_y = alu_a >> 1;
         OP_ARI_I: alu_y = alu_a << 1;
         OP_ARI_D: alu_y = {alu_a[N-1], alu_a[N-1:1]};
         default:  alu_y = alu_a + alu_b;
      endcase
      alu_flags = {alu_y[N-1], (alu_y == '0), alu_c};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] data;
      logic [2:0] flags;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: every response handshake is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_response: got data=%h flags=%b, required no response",
                     bus.res_data, bus.res_flags);
         end else begin
            e = exp_q.pop_front();
            if (bus.res_data !== e.data || bus.res_flags !== e.flags) begin
               n_miss++;
               $display("FAIL response: got data=%h flags=%b, required data=%h flags=%b",
                        bus.res_data, bus.res_flags, e.data, e.flags);
            end
         end
      end
   end

   task automatic wr(input int a, input int d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(a);
      bus.wr_data = 4'(d);
      @(posedge clk); #1;
      bus.wr_en   = 1'b0;
   endtask

   // Issues one command from IDLE; optional same-edge host write and response stall.
   task automatic issue(input logic [3:0] op, input int ra, input int rb, input int rd,
                        input int cnt, input logic [3:0] ed, input logic [2:0] ef,
                        input int elat, input int stall,
                        input bit wr_with, input int wa, input int wd);
      int lat;
      int g;
      check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
      exp_q.push_back({ed, ef});
      bus.res_ready = (stall == 0);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_ra    = 2'(ra);
      bus.cmd_rb    = 2'(rb);
      bus.cmd_rd    = 2'(rd);
      bus.cmd_count = 3'(cnt);
      if (wr_with) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = 2'(wa);
         bus.wr_data = 4'(wd);
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.wr_en     = 1'b0;
      lat = 1;
      while (bus.res_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(elat));
      for (int i = 0; i < stall; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = 2'd2;
         bus.wr_data = 4'hF;
         @(posedge clk); #1;
         check("stall_valid", 32'(bus.res_valid), 32'd1);
         check("stall_data", 32'(bus.res_data), 32'(ed));
         check("stall_flags", 32'(bus.res_flags), 32'(ef));
         check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      end
      bus.wr_en     = 1'b0;
      bus.res_ready = 1'b1;
      g = 0;
      while (bus.cmd_ready !== 1'b1 && g < 20) begin
         @(posedge clk); #1;
         g++;
      end
      check("return_idle", 32'(bus.cmd_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_ra    = '0;
      bus.cmd_rb    = '0;
      bus.cmd_rd    = '0;
      bus.cmd_count = '0;
      bus.res_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_res_data", 32'(bus.res_data), 32'd0);
      check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 9+9 wraps to 2 with carry
      wr(0, 9);
      wr(1, 9);
      issue(OP_SUMA, 0, 1, 2, 0, 4'h2, 3'b001, 3, 0, 1'b0, 0, 0);

      // 3-5 = E, held for 5 cycles while a host write to R2 is attempted
      wr(0, 5);
      wr(1, 3);
      issue(OP_RESTA, 1, 0, 3, 0, 4'hE, 3'b100, 3, 5, 1'b0, 0, 0);
      issue(OP_XOR, 3, 3, 3, 0, 4'h0, 3'b010, 3, 0, 1'b0, 0, 0);
      issue(OP_OR, 2, 2, 1, 0, 4'h2, 3'b000, 3, 0, 1'b0, 0, 0);

      // host write of R0=7 lands on the command edge: 7+7 = E
      issue(OP_SUMA, 0, 0, 2, 0, 4'hE, 3'b100, 3, 0, 1'b1, 0, 7);

      // multi-bit shift and count-0 shift
      wr(0, 3);
      issue(OP_LOG_I, 0, 1, 1, 3, 4'h8, 3'b100, 5, 0, 1'b0, 0, 0);
      issue(OP_LOG_I, 0, 1, 2, 0, 4'h6, 3'b000, 3, 0, 1'b0, 0, 0);
      issue(4'b1111, 0, 1, 3, 0, 4'hB, 3'b100, 3, 0, 1'b0, 0, 0);
      issue(OP_OR, 1, 1, 0, 0, 4'h8, 3'b100, 3, 0, 1'b0, 0, 0);
      issue(OP_ARI_D, 1, 1, 0, 2, 4'hE, 3'b100, 4, 0, 1'b0, 0, 0);

      // reset during the second EXEC cycle of a 3-step shift
      wr(0, 3);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_LOG_I;
      bus.cmd_ra    = 2'd0;
      bus.cmd_rb    = 2'd0;
      bus.cmd_rd    = 2'd3;
      bus.cmd_count = 3'd3;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("exec_busy", 32'(busy), 32'd1);
      check("exec_alu_ctrl", 32'(alu_ctrl), 32'(OP_LOG_I));
      check("exec_alu_a", 32'(alu_a), 32'h6);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
      check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("midrst_alu_ctrl", 32'(alu_ctrl), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_res_valid", 32'(bus.res_valid), 32'd0);
      issue(OP_OR, 3, 3, 0, 0, 4'h0, 3'b010, 3, 0, 1'b0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
